reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
- Parametrised successor to the processor's 2-read/1-write integer register file.
- Adds configurable data width and depth, an optional hardwired-zero register 0, and asynchronous reset clearing.
- Adds a per-register busy scoreboard for pending writebacks, used by the decode stage to detect read-after-write hazards.
- Sits between decode (read ports, busy-set) and writeback (write port, busy-clear).

Parameters:
- DATA_W, 32, width of each register and data ports.
- ADDR_W, 5, width of register address ports.
- DEPTH, 32, number of implemented registers; must be <= 2**ADDR_W.
- ZERO_REG, 1, when 1, register 0 always reads 0, ignores writes and never goes busy.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- writeCntrl  input  1  write enable, sampled on rising clk.
- writeAd  input  ADDR_W  write address.
- data  input  DATA_W  write data.
- readReg1  input  ADDR_W  read port 1 address.
- readReg2  input  ADDR_W  read port 2 address.
- read1  output  DATA_W  read port 1 data (combinational).
- read2  output  DATA_W  read port 2 data (combinational).
- busySet  input  1  mark register busyAd as pending-write at the next edge.
- busyAd  input  ADDR_W  register to mark pending.
- busy1  output  1  register at readReg1 is pending.
- busy2  output  1  register at readReg2 is pending.
- busyCount  output  ADDR_W+1  number of registers currently pending.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all registers = 0; all busy bits = 0; busyCount = 0.
  - read1/read2 therefore show 0 while reset is asserted.
  - Reset asserted mid-write discards that write.
- Write:
  - on rising clk with writeCntrl=1, writeAd < DEPTH and not (ZERO_REG and writeAd=0): reg[writeAd] <= data.
  - Any other write is dropped silently.
- Read:
  - read data is combinational from the register array, zero added latency.
  - Address >= DEPTH reads 0.
  - Address 0 reads 0 when ZERO_REG=1.
- Scoreboard, per-register busy bit:
  - Set at rising clk when busySet=1, busyAd < DEPTH and not (ZERO_REG and busyAd=0).
  - Cleared at rising clk by any accepted write to that address.
  - Simultaneous set and clear of the same address in one cycle: set wins, bit stays 1 (new producer issued).
  - Set and clear of different addresses in the same cycle both take effect.
  - Setting an already-busy bit leaves it 1 and does not change the count.
- busy1/busy2: combinational lookup of the current busy bits; 0 for out-of-range or zero-register addresses.
- busyCount:
  - registered; equals the population count of busy bits after each edge.
  - Increments and decrements are computed net: +1 for a new set, -1 for a clear of a busy bit, 0 if both.
  - Never exceeds DEPTH and never underflows; a clear of a non-busy register does not decrement.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - When writeCntrl=1 and writeAd equals readRegN (accepted write, nonzero or ZERO_REG=0), readN returns data in the same cycle.
  - busyN for that address reads 0 that cycle, unless busySet targets the same address in that cycle.
- Undefined:
  - Reads return the pre-edge stored value until after the write edge.
  - busyN stays 1 until the edge.

Decomposition:
- Shared package regfile_pkg holds:
  - default DATA_W, ADDR_W, DEPTH constants;
  - a ZERO_ADDR constant;
  - a function for in-range/writable address qualification, shared by the array and the scoreboard.
- One natural sub-module: reg_scoreboard. It holds the busy bit vector, set/clear priority logic and busyCount, and exposes per-address busy lookup.
- The register array and read muxing stay in reg_file_sb.

Test Plan:
- Reset then read all addresses -> read1=read2=0, busy1=busy2=0, busyCount=0.
- Write 0xDEADBEEF to reg 5; read reg 5 on both ports next cycle -> 0xDEADBEEF on read1 and read2.
- Write 0x12345678 to reg 0 with ZERO_REG=1 -> read of reg 0 returns 0.
- busySet reg 7 for one cycle, then write reg 7 three cycles later:
  - busy1 for reg 7 = 1 for three cycles, then 0;
  - busyCount goes 0->1->0.
- Same cycle: busySet reg 9 and write reg 9, with reg 9 already busy -> busy stays 1 and busyCount unchanged.
- Same-cycle write reg 3 = 0xA5A5A5A5 while reading reg 3:
  - with REGFILE_BYPASS_EN, read1=0xA5A5A5A5 that cycle;
  - without it, read1 shows the old value until the edge.
- Assert rst_n low mid-cycle with busyCount=4 -> all outputs 0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and address qualification for the register file and its scoreboard.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DEPTH  = 32;

    localparam int unsigned ZERO_ADDR = 0;

    // True when an address names an implemented register that can hold state.
    // The same rule decides whether a write lands, whether a busy bit may be set,
    // and whether a read port returns stored data instead of 0.
    function automatic logic addrOk(input int unsigned addr,
                                    input int unsigned depth,
                                    input logic        zeroReg);
        return (addr < depth) && !(zeroReg && (addr == ZERO_ADDR));
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-writeback scoreboard with a registered population count.
// Latency: set/clear take effect at the next rising clk; busy lookups are combinational.
// Backpressure: none; every qualified set/clear is taken each cycle.
//
// Ports: busySet/busyAd mark a register pending; clrEn/clrAd (the accepted write
// port) clear it; lookAd1/lookAd2 -> busy1/busy2; busyCount = number of busy bits.
// Build option: REGFILE_BYPASS_EN makes a same-cycle clear hide the busy bit on lookups.
module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              busySet,
    input  logic [ADDR_W-1:0] busyAd,
    input  logic              clrEn,
    input  logic [ADDR_W-1:0] clrAd,
    input  logic [ADDR_W-1:0] lookAd1,
    input  logic [ADDR_W-1:0] lookAd2,
    output logic              busy1,
    output logic              busy2,
    output logic [ADDR_W:0]   busyCount
);

    logic [DEPTH-1:0] busyVec;
    logic [DEPTH-1:0] busyNext;
    logic             setOk;
    logic             clrOk;
    logic             setWasBusy;
    logic             clrWasBusy;
    logic             sameAd;
    logic             incCnt;
    logic             decCnt;

    always_comb begin
        setOk      = busySet && addrOk(32'(busyAd), DEPTH, ZERO_REG != 0);
        clrOk      = clrEn && addrOk(32'(clrAd), DEPTH, ZERO_REG != 0);
        sameAd     = (busyAd == clrAd);
        setWasBusy = 1'b0;
        clrWasBusy = 1'b0;
        busyNext   = busyVec;
        for (int i = 0; i < DEPTH; i++) begin
            if (int'(busyAd) == i) setWasBusy = busyVec[i];
            if (int'(clrAd) == i)  clrWasBusy = busyVec[i];
            if (clrOk && (int'(clrAd) == i))  busyNext[i] = 1'b0;
            // Applied after the clear so a new producer wins over the retiring one.
            if (setOk && (int'(busyAd) == i)) busyNext[i] = 1'b1;
        end
        // Net count update: a set on a busy bit or a clear of an idle bit is a no-op,
        // and set+clear of the same busy register leaves it busy.
        incCnt = setOk && !setWasBusy;
        decCnt = clrOk && clrWasBusy && !(setOk && sameAd);
    end

    always_comb begin
        busy1 = 1'b0;
        busy2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (int'(lookAd1) == i) busy1 = busyVec[i];
            if (int'(lookAd2) == i) busy2 = busyVec[i];
        end
`ifdef REGFILE_BYPASS_EN
        // The write retiring this register is forwarded this cycle, so the hazard is
        // already resolved unless a new producer claims the same register now.
        if (clrOk && (lookAd1 == clrAd) && !(setOk && sameAd)) busy1 = 1'b0;
        if (clrOk && (lookAd2 == clrAd) && !(setOk && sameAd)) busy2 = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busyVec   <= '0;
            busyCount <= '0;
        end else begin
            busyVec   <= busyNext;
            busyCount <= busyCount + (ADDR_W+1)'(incCnt) - (ADDR_W+1)'(decCnt);
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// 2-read/1-write register file with optional hardwired zero register and busy scoreboard.
// Latency: writes land at the rising clk; reads and busy lookups are combinational.
// Backpressure: none; writes and busy-sets are accepted or silently dropped each cycle.
//
// Ports: writeCntrl/writeAd/data write port; readReg1/readReg2 -> read1/read2;
// busySet/busyAd mark pending writebacks; busy1/busy2 per read address; busyCount total.
// Build option: REGFILE_BYPASS_EN forwards same-cycle write data to the read ports.
module reg_file_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              writeCntrl,
    input  logic [ADDR_W-1:0] writeAd,
    input  logic [DATA_W-1:0] data,
    input  logic [ADDR_W-1:0] readReg1,
    input  logic [ADDR_W-1:0] readReg2,
    output logic [DATA_W-1:0] read1,
    output logic [DATA_W-1:0] read2,
    input  logic              busySet,
    input  logic [ADDR_W-1:0] busyAd,
    output logic              busy1,
    output logic              busy2,
    output logic [ADDR_W:0]   busyCount
);

    logic [DATA_W-1:0] regs [DEPTH];
    logic              wrOk;

    assign wrOk = writeCntrl && addrOk(32'(writeAd), DEPTH, ZERO_REG != 0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wrOk && (int'(writeAd) == i)) regs[i] <= data;
            end
        end
    end

    // Register 0 is never written when hardwired, so it needs no special read case;
    // addresses past DEPTH match no entry and fall through to 0.
    always_comb begin
        read1 = '0;
        read2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (int'(readReg1) == i) read1 = regs[i];
            if (int'(readReg2) == i) read2 = regs[i];
        end
`ifdef REGFILE_BYPASS_EN
        // Gated by rst_n so the ports stay 0 for the whole reset window.
        if (rst_n && wrOk && (writeAd == readReg1)) read1 = data;
        if (rst_n && wrOk && (writeAd == readReg2)) read2 = data;
`endif
    end

    reg_scoreboard #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG)
    ) uScoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .busySet   (busySet),
        .busyAd    (busyAd),
        .clrEn     (writeCntrl),
        .clrAd     (writeAd),
        .lookAd1   (readReg1),
        .lookAd2   (readReg2),
        .busy1     (busy1),
        .busy2     (busy2),
        .busyCount (busyCount)
    );

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed self-checking bench for reg_file_sb (default parameters).
// Latency: inputs driven 1ns after each rising edge, outputs checked 1ns later.
// Backpressure: n/a.
module tb_reg_file_sb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              writeCntrl;
    logic [ADDR_W-1:0] writeAd;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] readReg1;
    logic [ADDR_W-1:0] readReg2;
    logic [DATA_W-1:0] read1;
    logic [DATA_W-1:0] read2;
    logic              busySet;
    logic [ADDR_W-1:0] busyAd;
    logic              busy1;
    logic              busy2;
    logic [ADDR_W:0]   busyCount;

    int checks   = 0;
    int failures = 0;

    reg_file_sb dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .writeCntrl (writeCntrl),
        .writeAd    (writeAd),
        .data       (data),
        .readReg1   (readReg1),
        .readReg2   (readReg2),
        .read1      (read1),
        .read2      (read2),
        .busySet    (busySet),
        .busyAd     (busyAd),
        .busy1      (busy1),
        .busy2      (busy2),
        .busyCount  (busyCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs settle 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        writeCntrl = 1'b0;
        writeAd    = '0;
        data       = '0;
        readReg1   = 5'd5;
        readReg2   = 5'd31;
        busySet    = 1'b0;
        busyAd     = '0;

        // Reset state, observed while reset is held.
        #3;
        check("rst_read1", 64'(read1), 64'd0);
        check("rst_read2", 64'(read2), 64'd0);
        check("rst_busy1", 64'(busy1), 64'd0);
        check("rst_busy2", 64'(busy2), 64'd0);
        check("rst_count", 64'(busyCount), 64'd0);
        #5;
        rst_n = 1'b1;
        tick();

        // Every address reads 0 after reset.
        for (int a = 0; a < 32; a++) begin
            readReg1 = 5'(a);
            readReg2 = 5'(31 - a);
            #1;
            check("all_read1", 64'(read1), 64'd0);
            check("all_read2", 64'(read2), 64'd0);
            check("all_busy1", 64'(busy1 | busy2), 64'd0);
        end

        // Plain write, read back on both ports.
        writeCntrl = 1'b1; writeAd = 5'd5; data = 32'hDEADBEEF;
        tick();
        writeCntrl = 1'b0; readReg1 = 5'd5; readReg2 = 5'd5;
        #1;
        check("wr5_read1", 64'(read1), 64'hDEADBEEF);
        check("wr5_read2", 64'(read2), 64'hDEADBEEF);

        // Hardwired zero register ignores writes.
        writeCntrl = 1'b1; writeAd = 5'd0; data = 32'h12345678;
        tick();
        writeCntrl = 1'b0; readReg1 = 5'd0;
        #1;
        check("zero_read1", 64'(read1), 64'd0);

        // Zero register never goes busy.
        busySet = 1'b1; busyAd = 5'd0;
        tick();
        busySet = 1'b0;
        #1;
        check("zero_busy1", 64'(busy1), 64'd0);
        check("zero_count", 64'(busyCount), 64'd0);

        // Busy reg 7 for three cycles, cleared by the write on the third edge.
        busySet = 1'b1; busyAd = 5'd7; readReg1 = 5'd7;
        #1;
        check("b7_pre_busy", 64'(busy1), 64'd0);
        tick();
        busySet = 1'b0;
        #1;
        check("b7_c1_busy", 64'(busy1), 64'd1);
        check("b7_c1_count", 64'(busyCount), 64'd1);
        tick();
        check("b7_c2_busy", 64'(busy1), 64'd1);
        tick();
        writeCntrl = 1'b1; writeAd = 5'd7; data = 32'h00000777;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("b7_c3_busy", 64'(busy1), 64'd0);
        check("b7_c3_read", 64'(read1), 64'h777);
`else
        check("b7_c3_busy", 64'(busy1), 64'd1);
        check("b7_c3_read", 64'(read1), 64'd0);
`endif
        check("b7_c3_count", 64'(busyCount), 64'd1);
        tick();
        writeCntrl = 1'b0;
        #1;
        check("b7_done_busy", 64'(busy1), 64'd0);
        check("b7_done_count", 64'(busyCount), 64'd0);
        check("b7_done_read", 64'(read1), 64'h777);

        // Same-cycle set and write of an already-busy reg 9: set wins.
        busySet = 1'b1; busyAd = 5'd9; readReg2 = 5'd9;
        tick();
        check("b9_count", 64'(busyCount), 64'd1);
        writeCntrl = 1'b1; writeAd = 5'd9; data = 32'h99999999;
        #1;
        check("b9_same_busy", 64'(busy2), 64'd1);
        tick();
        busySet = 1'b0; writeCntrl = 1'b0;
        #1;
        check("b9_after_busy", 64'(busy2), 64'd1);
        check("b9_after_count", 64'(busyCount), 64'd1);
        check("b9_after_read", 64'(read2), 64'h99999999);

        // Set reg 10 and clear reg 9 in the same cycle: net count unchanged.
        busySet = 1'b1; busyAd = 5'd10;
        writeCntrl = 1'b1; writeAd = 5'd9; data = 32'h9999AAAA;
        readReg1 = 5'd10;
        tick();
        busySet = 1'b0;
        // Write to idle reg 11 must not decrement.
        writeAd = 5'd11; data = 32'h0000BBBB;
        #1;
        check("b10_busy1", 64'(busy1), 64'd1);
        check("b10_busy2", 64'(busy2), 64'd0);
        check("b10_count", 64'(busyCount), 64'd1);
        tick();
        writeCntrl = 1'b0;
        #1;
        check("b11_count", 64'(busyCount), 64'd1);

        // Same-cycle write and read of reg 3.
        writeCntrl = 1'b1; writeAd = 5'd3; data = 32'h11111111;
        tick();
        data = 32'hA5A5A5A5; readReg1 = 5'd3;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("byp3_read1", 64'(read1), 64'hA5A5A5A5);
`else
        check("byp3_read1", 64'(read1), 64'h11111111);
`endif
        tick();
        writeCntrl = 1'b0;
        #1;
        check("byp3_after", 64'(read1), 64'hA5A5A5A5);

        // Same-cycle write to the zero register never forwards.
        writeCntrl = 1'b1; writeAd = 5'd0; data = 32'hFFFFFFFF; readReg1 = 5'd0;
        #1;
        check("byp0_read1", 64'(read1), 64'd0);
        tick();
        writeCntrl = 1'b0;

        // Build up four busy registers (10 already busy), including a redundant set.
        busySet = 1'b1; busyAd = 5'd12;
        tick();
        busyAd = 5'd13;
        tick();
        busyAd = 5'd14;
        tick();
        busyAd = 5'd10;
        tick();
        busySet = 1'b0;
        readReg1 = 5'd5; readReg2 = 5'd10;
        #1;
        check("pre_rst_count", 64'(busyCount), 64'd4);
        check("pre_rst_busy2", 64'(busy2), 64'd1);
        check("pre_rst_read1", 64'(read1), 64'hDEADBEEF);

        // Asynchronous reset mid-cycle, with a write pending that must be discarded.
        writeCntrl = 1'b1; writeAd = 5'd5; data = 32'h55555555;
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_read1", 64'(read1), 64'd0);
        check("arst_read2", 64'(read2), 64'd0);
        check("arst_busy2", 64'(busy2), 64'd0);
        check("arst_count", 64'(busyCount), 64'd0);
        writeCntrl = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_read1", 64'(read1), 64'd0);
        check("post_rst_count", 64'(busyCount), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
